mem_issue_queue: RTL and testbench
==================================

// Module: mem_issue_queue
// PURPOSE
//  In-order issue queue upstream of the memory functional unit. Buffers load/store ops from issue,
//  captures missing rs1/rs2 operands from the CDB by tag, and dispatches the head to the memory FU
//  with a one-cycle EN pulse once its operands are ready. Waits for finish, then emits load results.
// PARAMETERS
//  DEPTH  4   queue entries (power of 2, >=2)
//  TAG_W  4   producer tag width on the CDB
// PORTS
//  clk            in   1      clock, all state on posedge
//  rst            in   1      asynchronous, active-high reset
//  enq_valid      in   1      issue presents an op
//  enq_ready      out  1      queue can accept (= not full)
//  enq_mem_w      in   1      1 = store, 0 = load
//  enq_bhw        in   3      funct3 width/sign code, passed through
//  enq_rd         in   5      load destination register
//  enq_imm        in   32     address offset
//  enq_rs1_rdy    in   1      rs1 value valid at enqueue
//  enq_rs1_tag    in   TAG_W  rs1 producer tag if not ready
//  enq_rs1_data   in   32     rs1 value if ready
//  enq_rs2_rdy/tag/data  in  1/TAG_W/32  same for rs2 (store data)
//  cdb_valid      in   1      result broadcast valid
//  cdb_tag        in   TAG_W  broadcast producer tag
//  cdb_data       in   32     broadcast value
//  fu_en          out  1      one-cycle dispatch pulse to memory FU
//  fu_mem_w       out  1      to FU: store flag
//  fu_bhw         out  3      to FU: width code
//  fu_rs1_data, fu_rs2_data, fu_imm  out  32 each  to FU operands
//  fu_finish      in   1      FU completion (one cycle after fu_en)
//  fu_mem_data    in   32     FU load data, valid while fu_finish
//  wb_valid       out  1      one-cycle load writeback pulse
//  wb_rd          out  5      writeback register
//  wb_data        out  32     writeback value
//  stall_cnt      out  32     head-blocked cycle count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: queue empty, ptrs/count 0, state IDLE; fu_en, wb_valid 0; fu_*/wb_rd/wb_data 0; stall_cnt 0.
//  Enqueue when enq_valid & enq_ready; enq_ready = (count != DEPTH); no pop-bypass when full.
//  Operand capture: each non-ready slot compares cdb_tag every cycle; match & cdb_valid -> data, rdy=1.
//  Enqueue with cdb_tag == enq tag same cycle: entry stored ready with cdb_data.
//  Loads need rs1 only; stores need rs1 and rs2. rs2_rdy ignored for loads.
//  FSM: IDLE -> ISSUE when head valid & operands ready; ISSUE (fu_en=1, fu_* driven from head)
//    -> WAIT; WAIT: on fu_finish pop head, if load pulse wb_valid with head rd and fu_mem_data,
//    -> IDLE. fu_en never high two cycles in a row. Issue-to-writeback latency 2 cycles.
//  Strict program order: no younger op dispatches past a blocked head.
//  fu_finish outside WAIT ignored. Enqueue and pop same cycle: count unchanged.
//  Pointers wrap modulo DEPTH. Reset mid-op: queue flushed; late fu_finish ignored.
//  fu_* held stable from ISSUE through WAIT.
// CONFIGURATION
//  MEMQ_STALL_CNT_EN defined: stall_cnt increments (wraps at 2^32) each cycle state==IDLE, head valid,
//    operands not ready. Undefined: counter not built, stall_cnt tied to 32'h0.
// STRUCTURE
//  Shared header mem_queue_defs: FSM state encodings (IDLE/ISSUE/WAIT), entry field widths, DEPTH default.
//  Sub-module memq_opnd_slot: one operand register with rdy/tag and CDB snoop; two per entry.
// TESTING
//  Load, rs1 ready=0x100, imm=4 -> fu_en 1 cycle later; fu_finish+0xDEAD -> wb_valid, rd=5, data 0xDEAD.
//  Store rs2 tag 3 not ready -> no fu_en; CDB tag 3 data 0x55 -> next cycle ISSUE, fu_rs2_data=0x55.
//  Fill 4 ops -> enq_ready=0 on 4th accept; 5th held; after one finish enq_ready=1, ordering kept.
//  Enqueue with CDB tag match same cycle -> entry ready, dispatches without further broadcast.
//  Assert rst during WAIT -> fu_en, wb_valid 0, queue empty; subsequent fu_finish produces no wb.
//  MEMQ_STALL_CNT_EN: head blocked 7 cycles -> stall_cnt == 7; undefined -> stall_cnt stays 0.

Source files
------------

// File: rtl/mem_issue_queue_pkg.sv
// rtl/mem_issue_queue_pkg.sv - shared FSM encodings, field widths and defaults for the memory issue queue
package mem_issue_queue_pkg;
    localparam int DEPTH_DEF = 4;
    localparam int TAG_W_DEF = 4;
    localparam int DATA_W    = 32;
    localparam int RD_W      = 5;
    localparam int BHW_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } memq_state_e;
endpackage

// File: rtl/mem_issue_queue_if.sv
// rtl/mem_issue_queue_if.sv - enqueue, CDB, memory-FU and writeback signal bundle
interface mem_issue_queue_if
    import mem_issue_queue_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
);
    logic              enq_valid;
    logic              enq_ready;
    logic              enq_mem_w;
    logic [BHW_W-1:0]  enq_bhw;
    logic [RD_W-1:0]   enq_rd;
    logic [DATA_W-1:0] enq_imm;
    logic              enq_rs1_rdy;
    logic [TAG_W-1:0]  enq_rs1_tag;
    logic [DATA_W-1:0] enq_rs1_data;
    logic              enq_rs2_rdy;
    logic [TAG_W-1:0]  enq_rs2_tag;
    logic [DATA_W-1:0] enq_rs2_data;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              fu_en;
    logic              fu_mem_w;
    logic [BHW_W-1:0]  fu_bhw;
    logic [DATA_W-1:0] fu_rs1_data;
    logic [DATA_W-1:0] fu_rs2_data;
    logic [DATA_W-1:0] fu_imm;
    logic              fu_finish;
    logic [DATA_W-1:0] fu_mem_data;
    logic              wb_valid;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  enq_valid, enq_mem_w, enq_bhw, enq_rd, enq_imm,
               enq_rs1_rdy, enq_rs1_tag, enq_rs1_data,
               enq_rs2_rdy, enq_rs2_tag, enq_rs2_data,
               cdb_valid, cdb_tag, cdb_data, fu_finish, fu_mem_data,
        output enq_ready, fu_en, fu_mem_w, fu_bhw, fu_rs1_data, fu_rs2_data, fu_imm,
               wb_valid, wb_rd, wb_data
    );

    modport master (
        output enq_valid, enq_mem_w, enq_bhw, enq_rd, enq_imm,
               enq_rs1_rdy, enq_rs1_tag, enq_rs1_data,
               enq_rs2_rdy, enq_rs2_tag, enq_rs2_data,
               cdb_valid, cdb_tag, cdb_data, fu_finish, fu_mem_data,
        input  enq_ready, fu_en, fu_mem_w, fu_bhw, fu_rs1_data, fu_rs2_data, fu_imm,
               wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/memq_opnd_slot.sv
// rtl/memq_opnd_slot.sv - one operand register with ready/tag that snoops the CDB
module memq_opnd_slot
    import mem_issue_queue_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              in_rdy,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_data,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              rdy,
    output logic [DATA_W-1:0] data
);
    logic              rdy_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] data_q;
    logic              hit;
    logic              in_hit;

    assign hit    = cdb_valid && !rdy_q && (cdb_tag == tag_q);
    assign in_hit = cdb_valid && (cdb_tag == in_tag);

    // A live broadcast is forwarded so the head can issue on the capture edge.
    assign rdy  = rdy_q | hit;
    assign data = rdy_q ? data_q : cdb_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q  <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else if (load) begin
            tag_q <= in_tag;
            if (in_rdy) begin
                rdy_q  <= 1'b1;
                data_q <= in_data;
            end else if (in_hit) begin
                rdy_q  <= 1'b1;
                data_q <= cdb_data;
            end else begin
                rdy_q  <= 1'b0;
            end
        end else if (hit) begin
            rdy_q  <= 1'b1;
            data_q <= cdb_data;
        end
    end
endmodule

// File: rtl/mem_issue_queue.sv
// rtl/mem_issue_queue.sv - in-order load/store issue queue feeding the memory FU
// Optional MEMQ_STALL_CNT_EN builds the head-blocked cycle counter on stall_cnt.
module mem_issue_queue
    import mem_issue_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mem_issue_queue_if.slave bus,
    output logic [31:0]      stall_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]  head, tail;
    logic [PTR_W:0]    count;
    logic [DEPTH-1:0]  vld, e_mem_w, r1_rdy, r2_rdy, slot_load;
    logic [BHW_W-1:0]  e_bhw   [DEPTH];
    logic [RD_W-1:0]   e_rd    [DEPTH];
    logic [DATA_W-1:0] e_imm   [DEPTH];
    logic [DATA_W-1:0] r1_data [DEPTH];
    logic [DATA_W-1:0] r2_data [DEPTH];
    memq_state_e       state, next_state;
    logic              do_enq, pop, head_rdy, head_load;

    assign bus.enq_ready = (count != FULL_CNT);
    assign do_enq        = bus.enq_valid & bus.enq_ready;
    assign pop           = (state == ST_WAIT) & bus.fu_finish;
    assign head_load     = ~e_mem_w[head];
    // Loads only need the address base; rs2 matters for stores alone.
    assign head_rdy      = vld[head] & r1_rdy[head] & (head_load | r2_rdy[head]);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign slot_load[i] = do_enq && (tail == PTR_W'(i));

        memq_opnd_slot #(.TAG_W(TAG_W)) u_rs1 (
            .clk(clk), .rst(rst), .load(slot_load[i]),
            .in_rdy(bus.enq_rs1_rdy), .in_tag(bus.enq_rs1_tag), .in_data(bus.enq_rs1_data),
            .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag), .cdb_data(bus.cdb_data),
            .rdy(r1_rdy[i]), .data(r1_data[i])
        );

        memq_opnd_slot #(.TAG_W(TAG_W)) u_rs2 (
            .clk(clk), .rst(rst), .load(slot_load[i]),
            .in_rdy(bus.enq_rs2_rdy), .in_tag(bus.enq_rs2_tag), .in_data(bus.enq_rs2_data),
            .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag), .cdb_data(bus.cdb_data),
            .rdy(r2_rdy[i]), .data(r2_data[i])
        );
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            e_mem_w[tail] <= bus.enq_mem_w;
            e_bhw[tail]   <= bus.enq_bhw;
            e_rd[tail]    <= bus.enq_rd;
            e_imm[tail]   <= bus.enq_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) begin
                vld[tail] <= 1'b1;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            case ({do_enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        bus.fu_en  = 1'b0;
        case (state)
            ST_IDLE:  if (head_rdy) next_state = ST_ISSUE;
            ST_ISSUE: begin
                bus.fu_en  = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT:  if (bus.fu_finish) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // FU operands latch on the IDLE->ISSUE edge and hold until the next dispatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fu_mem_w    <= 1'b0;
            bus.fu_bhw      <= '0;
            bus.fu_rs1_data <= '0;
            bus.fu_rs2_data <= '0;
            bus.fu_imm      <= '0;
            bus.wb_valid    <= 1'b0;
            bus.wb_rd       <= '0;
            bus.wb_data     <= '0;
        end else begin
            if (state == ST_IDLE && head_rdy) begin
                bus.fu_mem_w    <= e_mem_w[head];
                bus.fu_bhw      <= e_bhw[head];
                bus.fu_rs1_data <= r1_data[head];
                bus.fu_rs2_data <= r2_data[head];
                bus.fu_imm      <= e_imm[head];
            end
            bus.wb_valid <= pop & head_load;
            if (pop & head_load) begin
                bus.wb_rd   <= e_rd[head];
                bus.wb_data <= bus.fu_mem_data;
            end
        end
    end

`ifdef MEMQ_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          stall_cnt <= '0;
        else if (state == ST_IDLE && vld[head] && !head_rdy) stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_mem_issue_queue.sv
// tb/tb_mem_issue_queue.sv - directed and randomized self-checking bench for mem_issue_queue
module tb_mem_issue_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] stall_cnt;
    int          passed = 0;
    int          total  = 0;

`ifdef MEMQ_STALL_CNT_EN
    localparam logic [31:0] STALL_EXP = 32'd7;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    mem_issue_queue_if #(.TAG_W(4)) bus ();
    mem_issue_queue #(.DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem_w;
        logic [2:0]  bhw;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        r1_rdy;
        logic [3:0]  r1_tag;
        logic [31:0] r1_data;
        logic        r2_rdy;
        logic [3:0]  r2_tag;
        logic [31:0] r2_data;
    } op_t;

    task automatic idle_inputs();
        bus.enq_valid = 0; bus.enq_mem_w = 0; bus.enq_bhw = 0; bus.enq_rd = 0; bus.enq_imm = 0;
        bus.enq_rs1_rdy = 0; bus.enq_rs1_tag = 0; bus.enq_rs1_data = 0;
        bus.enq_rs2_rdy = 0; bus.enq_rs2_tag = 0; bus.enq_rs2_data = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
        bus.fu_finish = 0; bus.fu_mem_data = 0;
    endtask

    task automatic drive_enq(input logic mw, input logic [2:0] bhw, input logic [4:0] rd,
                             input logic [31:0] imm, input logic r1r, input logic [3:0] r1t,
                             input logic [31:0] r1d, input logic r2r, input logic [3:0] r2t,
                             input logic [31:0] r2d);
        bus.enq_valid = 1; bus.enq_mem_w = mw; bus.enq_bhw = bhw; bus.enq_rd = rd; bus.enq_imm = imm;
        bus.enq_rs1_rdy = r1r; bus.enq_rs1_tag = r1t; bus.enq_rs1_data = r1d;
        bus.enq_rs2_rdy = r2r; bus.enq_rs2_tag = r2t; bus.enq_rs2_data = r2d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.enq_ready !== 1'b1) $display("FAIL rst_enq_ready got %0b want 1", bus.enq_ready); else passed++;
        total++; if (bus.fu_en !== 1'b0) $display("FAIL rst_fu_en got %0b want 0", bus.fu_en); else passed++;
        total++; if (bus.wb_valid !== 1'b0) $display("FAIL rst_wb_valid got %0b want 0", bus.wb_valid); else passed++;
        total++; if (bus.fu_imm !== 32'h0 || bus.fu_rs1_data !== 32'h0) $display("FAIL rst_fu_ops got %0h/%0h want 0", bus.fu_imm, bus.fu_rs1_data); else passed++;
        total++; if (bus.wb_rd !== 5'd0 || bus.wb_data !== 32'h0) $display("FAIL rst_wb got %0h/%0h want 0", bus.wb_rd, bus.wb_data); else passed++;
        total++; if (stall_cnt !== 32'h0) $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); else passed++;
        rst = 0;
    endtask

    task automatic test_load();
        do_reset();
        @(negedge clk);
        drive_enq(1'b0, 3'd2, 5'd5, 32'd4, 1'b1, 4'd0, 32'h100, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        bus.enq_valid = 0;
        total++; if (bus.fu_en !== 1'b0) $display("FAIL load_early_fu_en got %0b want 0", bus.fu_en); else passed++;
        @(negedge clk);
        total++; if (bus.fu_en !== 1'b1) $display("FAIL load_fu_en got %0b want 1", bus.fu_en); else passed++;
        total++; if (bus.fu_rs1_data !== 32'h100 || bus.fu_imm !== 32'd4 || bus.fu_mem_w !== 1'b0)
            $display("FAIL load_fu_ops got rs1=%0h imm=%0h w=%0b want 100/4/0", bus.fu_rs1_data, bus.fu_imm, bus.fu_mem_w); else passed++;
        @(negedge clk);
        total++; if (bus.fu_en !== 1'b0) $display("FAIL load_fu_en_pulse got %0b want 0", bus.fu_en); else passed++;
        total++; if (bus.fu_rs1_data !== 32'h100) $display("FAIL load_fu_hold got %0h want 100", bus.fu_rs1_data); else passed++;
        bus.fu_finish = 1; bus.fu_mem_data = 32'hDEAD;
        @(negedge clk);
        bus.fu_finish = 0;
        total++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'hDEAD)
            $display("FAIL load_wb got v=%0b rd=%0d d=%0h want 1/5/dead", bus.wb_valid, bus.wb_rd, bus.wb_data); else passed++;
        @(negedge clk);
        total++; if (bus.wb_valid !== 1'b0) $display("FAIL load_wb_pulse got %0b want 0", bus.wb_valid); else passed++;
    endtask

    task automatic test_store_cdb();
        do_reset();
        @(negedge clk);
        drive_enq(1'b1, 3'd2, 5'd0, 32'd8, 1'b1, 4'd0, 32'h200, 1'b0, 4'd3, 32'h0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            bus.enq_valid = 0;
            total++; if (bus.fu_en !== 1'b0) $display("FAIL store_blocked_fu_en cycle %0d got %0b want 0", i, bus.fu_en); else passed++;
        end
        @(negedge clk);
        total++; if (stall_cnt !== STALL_EXP) $display("FAIL stall_cnt got %0d want %0d", stall_cnt, STALL_EXP); else passed++;
        bus.cdb_valid = 1; bus.cdb_tag = 4'd3; bus.cdb_data = 32'h55;
        @(negedge clk);
        bus.cdb_valid = 0;
        total++; if (bus.fu_en !== 1'b1) $display("FAIL store_fu_en got %0b want 1", bus.fu_en); else passed++;
        total++; if (bus.fu_rs2_data !== 32'h55 || bus.fu_rs1_data !== 32'h200 || bus.fu_mem_w !== 1'b1 || bus.fu_bhw !== 3'd2 || bus.fu_imm !== 32'd8)
            $display("FAIL store_fu_ops got rs2=%0h rs1=%0h w=%0b bhw=%0d imm=%0h", bus.fu_rs2_data, bus.fu_rs1_data, bus.fu_mem_w, bus.fu_bhw, bus.fu_imm); else passed++;
        @(negedge clk);
        bus.fu_finish = 1; bus.fu_mem_data = 32'hBEEF;
        @(negedge clk);
        bus.fu_finish = 0;
        total++; if (bus.wb_valid !== 1'b0) $display("FAIL store_no_wb got %0b want 0", bus.wb_valid); else passed++;
        @(negedge clk);
        total++; if (stall_cnt !== STALL_EXP) $display("FAIL stall_cnt_hold got %0d want %0d", stall_cnt, STALL_EXP); else passed++;
    endtask

    task automatic test_fill();
        int w;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (bus.enq_ready !== 1'b1) $display("FAIL fill_ready_%0d got %0b want 1", i, bus.enq_ready); else passed++;
            drive_enq(1'b0, 3'd0, 5'(10 + i), 32'(i), 1'b1, 4'd0, 32'h1000 + 32'(i), 1'b0, 4'd0, 32'h0);
        end
        @(negedge clk);
        total++; if (bus.enq_ready !== 1'b0) $display("FAIL fill_full got %0b want 0", bus.enq_ready); else passed++;
        drive_enq(1'b0, 3'd0, 5'd14, 32'd4, 1'b1, 4'd0, 32'h1004, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        total++; if (bus.enq_ready !== 1'b0) $display("FAIL fill_held got %0b want 0", bus.enq_ready); else passed++;
        bus.fu_finish = 1; bus.fu_mem_data = 32'hA0;
        @(negedge clk);
        bus.fu_finish = 0;
        total++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd10 || bus.wb_data !== 32'hA0)
            $display("FAIL fill_wb0 got v=%0b rd=%0d d=%0h want 1/10/a0", bus.wb_valid, bus.wb_rd, bus.wb_data); else passed++;
        total++; if (bus.enq_ready !== 1'b1) $display("FAIL fill_reopen got %0b want 1", bus.enq_ready); else passed++;
        @(negedge clk);
        bus.enq_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            w = 0;
            while (bus.fu_en !== 1'b1 && w < 10) begin
                @(negedge clk);
                w++;
            end
            total++; if (bus.fu_en !== 1'b1) $display("FAIL fill_wait_fu_en op %0d got timeout want fu_en", k); else passed++;
            total++; if (bus.fu_rs1_data !== 32'h1000 + 32'(k) || bus.fu_imm !== 32'(k))
                $display("FAIL fill_order op %0d got rs1=%0h imm=%0h want %0h/%0h", k, bus.fu_rs1_data, bus.fu_imm, 32'h1000 + k, k); else passed++;
            @(negedge clk);
            bus.fu_finish = 1; bus.fu_mem_data = 32'hB0 + 32'(k);
            @(negedge clk);
            bus.fu_finish = 0;
            total++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'(10 + k) || bus.wb_data !== 32'hB0 + 32'(k))
                $display("FAIL fill_wb op %0d got v=%0b rd=%0d d=%0h", k, bus.wb_valid, bus.wb_rd, bus.wb_data); else passed++;
        end
    endtask

    task automatic test_enq_cdb_match();
        do_reset();
        @(negedge clk);
        drive_enq(1'b0, 3'd1, 5'd7, 32'd0, 1'b0, 4'd9, 32'h0, 1'b0, 4'd0, 32'h0);
        bus.cdb_valid = 1; bus.cdb_tag = 4'd9; bus.cdb_data = 32'h77;
        @(negedge clk);
        bus.enq_valid = 0; bus.cdb_valid = 0;
        @(negedge clk);
        total++; if (bus.fu_en !== 1'b1 || bus.fu_rs1_data !== 32'h77)
            $display("FAIL enq_cdb_match got en=%0b rs1=%0h want 1/77", bus.fu_en, bus.fu_rs1_data); else passed++;
        @(negedge clk);
        bus.fu_finish = 1; bus.fu_mem_data = 32'h1234;
        @(negedge clk);
        bus.fu_finish = 0;
        total++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd7 || bus.wb_data !== 32'h1234)
            $display("FAIL enq_cdb_wb got v=%0b rd=%0d d=%0h want 1/7/1234", bus.wb_valid, bus.wb_rd, bus.wb_data); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        drive_enq(1'b0, 3'd0, 5'd3, 32'd0, 1'b1, 4'd0, 32'h30, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        drive_enq(1'b0, 3'd0, 5'd4, 32'd0, 1'b1, 4'd0, 32'h40, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        bus.enq_valid = 0;
        total++; if (bus.fu_en !== 1'b1) $display("FAIL midrst_dispatch got %0b want 1", bus.fu_en); else passed++;
        @(negedge clk);
        rst = 1;
        #1;
        total++; if (bus.fu_en !== 1'b0 || bus.wb_valid !== 1'b0 || bus.enq_ready !== 1'b1)
            $display("FAIL midrst_outputs got en=%0b wb=%0b rdy=%0b want 0/0/1", bus.fu_en, bus.wb_valid, bus.enq_ready); else passed++;
        @(negedge clk);
        rst = 0;
        bus.fu_finish = 1; bus.fu_mem_data = 32'hBAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.fu_finish = 0;
            total++; if (bus.wb_valid !== 1'b0 || bus.fu_en !== 1'b0)
                $display("FAIL midrst_quiet cycle %0d got wb=%0b en=%0b want 0/0", i, bus.wb_valid, bus.fu_en); else passed++;
        end
    endtask

    task automatic test_random();
        op_t         mq[$];
        op_t         cur;
        op_t         nw;
        bit          inflight = 0, fin_stage = 0, wb_exp = 0, prev_en = 0, pop_edge;
        logic [4:0]  exp_rd = 0;
        logic [31:0] exp_data = 0;
        int          n_disp = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            total++; if (bus.enq_ready !== ((mq.size() + int'(inflight)) != 4))
                $display("FAIL rnd_enq_ready cyc %0d got %0b occupancy %0d", cyc, bus.enq_ready, mq.size() + int'(inflight)); else passed++;
            total++; if (bus.wb_valid !== wb_exp) $display("FAIL rnd_wb_valid cyc %0d got %0b want %0b", cyc, bus.wb_valid, wb_exp); else passed++;
            if (wb_exp) begin
                total++; if (bus.wb_rd !== exp_rd || bus.wb_data !== exp_data)
                    $display("FAIL rnd_wb cyc %0d got rd=%0d d=%0h want %0d/%0h", cyc, bus.wb_rd, bus.wb_data, exp_rd, exp_data); else passed++;
            end
            wb_exp = 0;
            pop_edge = 0;
            bus.fu_finish = fin_stage;
            if (fin_stage) begin
                bus.fu_mem_data = $urandom;
                wb_exp = !cur.mem_w;
                exp_rd = cur.rd;
                exp_data = bus.fu_mem_data;
                pop_edge = 1;
                fin_stage = 0;
            end
            if (bus.fu_en === 1'b1) begin
                total++; if (prev_en) $display("FAIL rnd_fu_en_twice cyc %0d got 1 want 0", cyc); else passed++;
                total++; if (mq.size() == 0 || inflight) $display("FAIL rnd_spurious_dispatch cyc %0d got fu_en want none", cyc); else passed++;
                if (mq.size() != 0 && !inflight) begin
                    cur = mq.pop_front();
                    inflight = 1; fin_stage = 1; n_disp++;
                    total++; if (!cur.r1_rdy || (cur.mem_w && !cur.r2_rdy))
                        $display("FAIL rnd_early_dispatch cyc %0d got fu_en want operands ready", cyc); else passed++;
                    total++; if (bus.fu_mem_w !== cur.mem_w || bus.fu_bhw !== cur.bhw || bus.fu_imm !== cur.imm || bus.fu_rs1_data !== cur.r1_data)
                        $display("FAIL rnd_fu_ops cyc %0d got w=%0b bhw=%0d imm=%0h rs1=%0h want %0b/%0d/%0h/%0h", cyc,
                                 bus.fu_mem_w, bus.fu_bhw, bus.fu_imm, bus.fu_rs1_data, cur.mem_w, cur.bhw, cur.imm, cur.r1_data); else passed++;
                    if (cur.mem_w) begin
                        total++; if (bus.fu_rs2_data !== cur.r2_data)
                            $display("FAIL rnd_fu_rs2 cyc %0d got %0h want %0h", cyc, bus.fu_rs2_data, cur.r2_data); else passed++;
                    end
                end
            end
            prev_en = (bus.fu_en === 1'b1);
            if (cyc < 2400) begin
                bus.cdb_valid = ($urandom % 3 == 0);
                bus.cdb_tag = 4'($urandom);
            end else begin
                bus.cdb_valid = 1;
                bus.cdb_tag = 4'(cyc);
            end
            bus.cdb_data = $urandom;
            bus.enq_valid = 0;
            if (cyc < 2400 && ($urandom % 2 == 0)) begin
                nw.mem_w = 1'($urandom); nw.bhw = 3'($urandom); nw.rd = 5'($urandom); nw.imm = $urandom;
                nw.r1_rdy = 1'($urandom); nw.r1_tag = 4'($urandom); nw.r1_data = $urandom;
                nw.r2_rdy = 1'($urandom); nw.r2_tag = 4'($urandom); nw.r2_data = $urandom;
                drive_enq(nw.mem_w, nw.bhw, nw.rd, nw.imm, nw.r1_rdy, nw.r1_tag, nw.r1_data, nw.r2_rdy, nw.r2_tag, nw.r2_data);
            end
            // Model the coming clock edge: broadcast capture, then acceptance, then pop.
            if (bus.cdb_valid) begin
                foreach (mq[j]) begin
                    if (!mq[j].r1_rdy && mq[j].r1_tag == bus.cdb_tag) begin mq[j].r1_rdy = 1; mq[j].r1_data = bus.cdb_data; end
                    if (!mq[j].r2_rdy && mq[j].r2_tag == bus.cdb_tag) begin mq[j].r2_rdy = 1; mq[j].r2_data = bus.cdb_data; end
                end
            end
            if (bus.enq_valid && bus.enq_ready === 1'b1) begin
                if (!nw.r1_rdy && bus.cdb_valid && nw.r1_tag == bus.cdb_tag) begin nw.r1_rdy = 1; nw.r1_data = bus.cdb_data; end
                if (!nw.r2_rdy && bus.cdb_valid && nw.r2_tag == bus.cdb_tag) begin nw.r2_rdy = 1; nw.r2_data = bus.cdb_data; end
                mq.push_back(nw);
            end
            if (pop_edge) inflight = 0;
        end
        idle_inputs();
        total++; if (mq.size() != 0 || inflight) $display("FAIL rnd_drain got %0d ops left want 0", mq.size() + int'(inflight)); else passed++;
        total++; if (n_disp < 100) $display("FAIL rnd_throughput got %0d dispatches want >= 100", n_disp); else passed++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load();
        test_store_cdb();
        test_fill();
        test_enq_cdb_match();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
